// File: rtl/day01_pkg.sv
// Shared constants and FSM encoding for the Day 1 front-end.
// Imported by the line parser and its decimal accumulator.
package day01_pkg;

    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_NL = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        S_REQ,
        S_DAT,
        S_EMIT,
        S_DONE
    } state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

    function automatic logic is_dir(input logic [7:0] b);
        return (b == CH_L) || (b == CH_R);
    endfunction

endpackage

// File: rtl/day01_dec_accum.sv
// Combinational acc*10+digit step with saturation to all-ones.
// Overflow is judged on the full-precision result.
module day01_dec_accum
    import day01_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] acc_i,
    input  logic [3:0]   digit_i,
    output logic [W-1:0] acc_o,
    output logic         ovf_o
);

    localparam logic [W+4:0] TEN = (W+5)'(10);

    logic [W+4:0] full;

    always_comb begin
        full  = ({5'd0, acc_i} * TEN) + {{(W+1){1'b0}}, digit_i};
        ovf_o = |full[W+4:W];
        acc_o = ovf_o ? '1 : full[W-1:0];
    end

endmodule

// File: rtl/day01_line_parser.sv
// Walks the puzzle ROM and turns each "L68"/"R48" line into a token.
// Two cycles per byte: request the address, then classify the byte.
module day01_line_parser
    import day01_pkg::*;
#(
    parameter int N_ADDR_BITS      = 16,
    parameter int INPUT_DATA_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [N_ADDR_BITS:0]        rom_addr,
    input  logic [7:0]                  rom_data,
    input  logic                        rom_valid,
    output logic                        tok_valid,
    input  logic                        tok_ready,
    output logic                        tok_dir,
    output logic [INPUT_DATA_WIDTH-1:0] tok_dist,
    output logic                        done,
    output logic                        err
);

    localparam int W  = INPUT_DATA_WIDTH;
    localparam int AW = N_ADDR_BITS + 1;

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           have_dir_q, have_dir_d;
    logic [3:0]     ndig_q, ndig_d;
    logic           dir_q, dir_d;
    logic [W-1:0]   acc_q, acc_d;
    logic           skip_q, skip_d;
    logic           err_q, err_d;
    logic           eof_q, eof_d;
    logic           tdir_q, tdir_d;
    logic [W-1:0]   tdist_q, tdist_d;

    logic [W-1:0]   acc_nx;
    logic           acc_ovf;
    logic           emit;
    logic           bad;
    logic           clr;
    logic           last;
    logic           pend;
    logic           part;

    day01_dec_accum #(
        .W (W)
    ) u_accum (
        .acc_i   (acc_q),
        .digit_i (rom_data[3:0]),
        .acc_o   (acc_nx),
        .ovf_o   (acc_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            addr_q     <= '0;
            have_dir_q <= 1'b0;
            ndig_q     <= '0;
            dir_q      <= DIR_LEFT;
            acc_q      <= '0;
            skip_q     <= 1'b0;
            err_q      <= 1'b0;
            eof_q      <= 1'b0;
            tdir_q     <= DIR_LEFT;
            tdist_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            have_dir_q <= have_dir_d;
            ndig_q     <= ndig_d;
            dir_q      <= dir_d;
            acc_q      <= acc_d;
            skip_q     <= skip_d;
            err_q      <= err_d;
            eof_q      <= eof_d;
            tdir_q     <= tdir_d;
            tdist_q    <= tdist_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        have_dir_d = have_dir_q;
        ndig_d     = ndig_q;
        dir_d      = dir_q;
        acc_d      = acc_q;
        skip_d     = skip_q;
        err_d      = err_q;
        eof_d      = eof_q;
        tdir_d     = tdir_q;
        tdist_d    = tdist_q;
        emit       = 1'b0;
        bad        = 1'b0;
        clr        = 1'b0;
        pend       = 1'b0;
        part       = 1'b0;
        last       = &addr_q;

        unique case (state_q)
            S_REQ: begin
                state_d = S_DAT;
            end

            S_DAT: begin
                if (rom_valid && skip_q) begin
                    clr = (rom_data == CH_NL);
                end else if (rom_valid) begin
                    unique case (1'b1)
                        is_dir(rom_data): begin
                            if (!have_dir_q) begin
                                have_dir_d = 1'b1;
                                dir_d = (rom_data == CH_R) ? DIR_RIGHT : DIR_LEFT;
                            end else begin
                                bad = 1'b1;
                            end
                        end
                        is_digit(rom_data): begin
                            if (have_dir_q) begin
                                acc_d = acc_nx;
                                if (ndig_q != 4'hF) ndig_d = ndig_q + 4'd1;
                                if (acc_ovf) err_d = 1'b1;
                            end else begin
                                bad = 1'b1;
                            end
                        end
                        (rom_data == CH_CR): begin
                        end
                        (rom_data == CH_NL): begin
                            if (have_dir_q && (ndig_q != '0)) begin
                                emit = 1'b1;
                            end else if (have_dir_q) begin
                                err_d = 1'b1;
                                clr   = 1'b1;
                            end
                        end
                        default: begin
                            bad = 1'b1;
                        end
                    endcase
                end

                if (bad) begin
                    err_d  = 1'b1;
                    skip_d = 1'b1;
                end
                if (clr) begin
                    have_dir_d = 1'b0;
                    ndig_d     = '0;
                    dir_d      = DIR_LEFT;
                    acc_d      = '0;
                    skip_d     = 1'b0;
                end

                // End of file is judged on the context after this byte.
                pend = have_dir_d && (ndig_d != '0);
                part = have_dir_d || (ndig_d != '0) || skip_d;

                if (emit) begin
                    tdir_d  = dir_q;
                    tdist_d = acc_q;
                    eof_d   = last;
                    state_d = S_EMIT;
                    addr_d  = addr_q + AW'(1);
                end else if (!rom_valid || last) begin
                    if (pend) begin
                        tdir_d  = dir_d;
                        tdist_d = acc_d;
                        eof_d   = 1'b1;
                        state_d = S_EMIT;
                        addr_d  = addr_q + AW'(1);
                    end else begin
                        if (part) err_d = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_REQ;
                    addr_d  = addr_q + AW'(1);
                end
            end

            S_EMIT: begin
                if (tok_ready) begin
                    have_dir_d = 1'b0;
                    ndig_d     = '0;
                    dir_d      = DIR_LEFT;
                    acc_d      = '0;
                    skip_d     = 1'b0;
                    eof_d      = 1'b0;
                    state_d    = eof_q ? S_DONE : S_REQ;
                end
            end

            S_DONE: begin
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    assign rom_addr  = addr_q;
    assign tok_valid = (state_q == S_EMIT);
    assign tok_dir   = tdir_q;
    assign tok_dist  = tdist_q;
    assign done      = (state_q == S_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_day01_line_parser.sv
// Directed bench for day01_line_parser with a registered ROM model.
// Runs a 16-bit and an 8-bit distance instance off the same ROM image.
module tb_day01_line_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tok_ready = 1'b0;
    logic        sel8 = 1'b0;

    logic [16:0] a16, a8;
    logic [7:0]  d16, d8;
    logic        v16, v8;
    logic        tv16, tv8, dir16, dir8, dn16, dn8, er16, er8;
    logic [15:0] dist16;
    logic [7:0]  dist8;

    logic [7:0]  mem [0:63];
    int          len = 0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [16:0] tq [$];

    logic        cur_tv, cur_dir, cur_done, cur_err;
    logic [15:0] cur_dist;
    logic [16:0] cur_addr;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        d16 <= mem[a16[5:0]];
        v16 <= (int'(a16) < len);
        d8  <= mem[a8[5:0]];
        v8  <= (int'(a8) < len);
    end

    assign cur_tv   = sel8 ? tv8 : tv16;
    assign cur_dir  = sel8 ? dir8 : dir16;
    assign cur_done = sel8 ? dn8 : dn16;
    assign cur_err  = sel8 ? er8 : er16;
    assign cur_dist = sel8 ? {8'd0, dist8} : dist16;
    assign cur_addr = sel8 ? a8 : a16;

    day01_line_parser #(
        .N_ADDR_BITS      (16),
        .INPUT_DATA_WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rom_addr  (a16),
        .rom_data  (d16),
        .rom_valid (v16),
        .tok_valid (tv16),
        .tok_ready (tok_ready),
        .tok_dir   (dir16),
        .tok_dist  (dist16),
        .done      (dn16),
        .err       (er16)
    );

    day01_line_parser #(
        .N_ADDR_BITS      (16),
        .INPUT_DATA_WIDTH (8)
    ) dut8 (
        .clk       (clk),
        .rst       (rst),
        .rom_addr  (a8),
        .rom_data  (d8),
        .rom_valid (v8),
        .tok_valid (tv8),
        .tok_ready (tok_ready),
        .tok_dir   (dir8),
        .tok_dist  (dist8),
        .done      (dn8),
        .err       (er8)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input string s);
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) mem[i] = s[i];
        len = s.len();
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_addr"}, 32'(cur_addr), 0);
        check({tag, "_tv"},   32'(cur_tv),   0);
        check({tag, "_dir"},  32'(cur_dir),  0);
        check({tag, "_dist"}, 32'(cur_dist), 0);
        check({tag, "_done"}, 32'(cur_done), 0);
        check({tag, "_err"},  32'(cur_err),  0);
    endtask

    task automatic run(input string tag, input int stall);
        int          stalled;
        logic        bad;
        logic        tmo;
        logic [16:0] a0;
        logic [15:0] d0;
        tq.delete();
        stalled   = 0;
        bad       = 1'b0;
        tmo       = 1'b1;
        a0        = '0;
        d0        = '0;
        tok_ready = (stall == 0);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (cur_done) begin
                tmo = 1'b0;
                break;
            end
            if (cur_tv) begin
                if (tok_ready) begin
                    tq.push_back({cur_dir, cur_dist});
                end else begin
                    if (stalled == 0) begin
                        a0 = cur_addr;
                        d0 = cur_dist;
                    end else if (cur_addr != a0 || cur_dist != d0) begin
                        bad = 1'b1;
                    end
                    stalled++;
                    if (stalled >= stall) begin
                        tok_ready = 1'b1;
                        tq.push_back({cur_dir, cur_dist});
                    end
                end
            end else if (!tok_ready && stalled > 0) begin
                bad = 1'b1;
            end
        end
        check({tag, "_timeout"}, 32'(tmo), 0);
        if (stall > 0) begin
            check({tag, "_stall_stable"}, 32'(bad), 0);
            check({tag, "_stall_cycles"}, stalled, stall);
        end
    endtask

    task automatic expect_toks(input string tag, input int n,
                               input logic [16:0] e0, input logic [16:0] e1);
        logic [16:0] got;
        logic [16:0] exp;
        check({tag, "_ntok"}, tq.size(), n);
        for (int i = 0; i < n; i++) begin
            got = (i < tq.size()) ? tq[i] : 17'h1FFFF;
            exp = (i == 0) ? e0 : e1;
            check($sformatf("%s_tok%0d", tag, i), 32'(got), 32'(exp));
        end
    endtask

    initial begin
        load("L68\nR48\n");
        hold_reset();
        check_reset_vals("rst0");
        rst = 1'b0;

        run("s1", 0);
        expect_toks("s1", 2, {1'b0, 16'd68}, {1'b1, 16'd48});
        check("s1_done", 32'(cur_done), 1);
        check("s1_err", 32'(cur_err), 0);
        repeat (5) @(negedge clk);
        check("s1_idle_tv", 32'(cur_tv), 0);
        check("s1_addr_frozen", 32'(cur_addr), 8);

        hold_reset();
        rst = 1'b0;
        run("s2", 10);
        expect_toks("s2", 2, {1'b0, 16'd68}, {1'b1, 16'd48});
        check("s2_done", 32'(cur_done), 1);

        load("R5\r\n\nL123");
        hold_reset();
        rst = 1'b0;
        run("s3", 0);
        expect_toks("s3", 2, {1'b1, 16'd5}, {1'b0, 16'd123});
        check("s3_done", 32'(cur_done), 1);
        check("s3_err", 32'(cur_err), 0);

        load("X7\nL9\n");
        hold_reset();
        rst = 1'b0;
        run("s4", 0);
        expect_toks("s4", 1, {1'b0, 16'd9}, 17'd0);
        check("s4_done", 32'(cur_done), 1);
        check("s4_err", 32'(cur_err), 1);

        sel8 = 1'b1;
        load("R300\nL2\n");
        hold_reset();
        rst = 1'b0;
        run("s5", 0);
        expect_toks("s5", 2, {1'b1, 16'd255}, {1'b0, 16'd2});
        check("s5_err", 32'(cur_err), 1);
        check("s5_done", 32'(cur_done), 1);
        sel8 = 1'b0;

        load("");
        hold_reset();
        rst = 1'b0;
        run("s6", 0);
        expect_toks("s6", 0, 17'd0, 17'd0);
        check("s6_done", 32'(cur_done), 1);
        check("s6_err", 32'(cur_err), 0);
        check("s6_addr", 32'(cur_addr), 0);

        load("L68\nR48\n");
        hold_reset();
        rst = 1'b0;
        tok_ready = 1'b1;
        begin
            logic hit;
            hit = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (cur_addr == 17'd6) begin
                    hit = 1'b1;
                    break;
                end
            end
            check("s7_reach_addr6", 32'(hit), 1);
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("s7_mid");
        rst = 1'b0;
        run("s7", 0);
        expect_toks("s7", 2, {1'b0, 16'd68}, {1'b1, 16'd48});
        check("s7_done", 32'(cur_done), 1);
        check("s7_err", 32'(cur_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/day01_line_parser.md
Name: day01_line_parser

Overview:
- Upstream front-end for the Day 1 solver. Walks the byte-addressed puzzle ROM from address 0 and parses each text line ("L68", "R48", ...) into one rotation token: a direction and a distance.
- Hands tokens to the dial-counting stage over a valid/ready handshake.
- Signals done once end-of-file is reached and the last token has been accepted.

Parameters:
- N_ADDR_BITS, 16, ROM address width minus one; rom_addr is N_ADDR_BITS+1 bits.
- INPUT_DATA_WIDTH, 16, width of the parsed distance field.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rom_addr  out  N_ADDR_BITS+1  byte address to ROM.
- rom_data  in  8  ROM byte. Registered: reflects the rom_addr of the previous cycle.
- rom_valid  in  1  1 = rom_data is a file byte; 0 = address is past end of file.
- tok_valid  out  1  token available.
- tok_ready  in  1  consumer accepts the token.
- tok_dir  out  1  0 = L (left), 1 = R (right).
- tok_dist  out  INPUT_DATA_WIDTH  parsed distance.
- done  out  1  sticky; all input consumed and last token accepted.
- err  out  1  sticky; malformed line or distance overflow seen.

Behaviour:
- Reset values: rom_addr=0, tok_valid=0, tok_dir=0, tok_dist=0, done=0, err=0.
- Reset applies only on posedge clk with rst=1. A reset mid-operation discards any partial line or pending token and restarts at address 0.
- FSM states:
  - S_REQ: rom_addr holds the current address; go to S_DAT.
  - S_DAT: sample rom_data and rom_valid; classify the byte (see below).
  - S_EMIT: present the token.
  - S_DONE: terminal.
- Throughput is 2 cycles per byte. rom_addr increments on leaving S_DAT, except when the FSM goes to S_DONE.
- Per-line context: have_dir, n_digits, dir, acc[INPUT_DATA_WIDTH-1:0], skip. All are cleared at line start.
- Byte classes, when rom_valid=1 and skip=0:
  - 'L'/'R' with have_dir=0 sets dir and have_dir.
  - '0'..'9' with have_dir=1 computes acc = acc*10 + digit, in full precision.
  - If that result exceeds 2^INPUT_DATA_WIDTH-1: acc saturates to all-ones and err is set.
  - '\r' is ignored.
  - '\n' with have_dir=1 and n_digits>=1 goes to S_EMIT.
  - '\n' with have_dir=0 and n_digits=0 (blank line) is ignored.
  - Any other byte, a digit before a direction, or a second direction: set err, set skip.
- When skip=1, all bytes are discarded until '\n'. That '\n' clears the line context and emits nothing.
- End of file (rom_valid=0, or rom_addr at all-ones after its byte is processed):
  - If have_dir=1 and n_digits>=1, the pending token goes to S_EMIT, then S_DONE.
  - Any other partial line sets err and goes straight to S_DONE.
- S_EMIT: tok_valid=1 with tok_dir/tok_dist stable. When tok_valid & tok_ready on a posedge, the transfer occurs. Next cycle tok_valid=0, the line context is cleared, and the FSM returns to S_REQ (or S_DONE after the EOF token).
- tok_valid never drops without a transfer.
- tok_dir/tok_dist hold their last value while tok_valid=0.
- S_DONE: done=1, rom_addr frozen, tok_valid=0. Exited only by rst.
- An empty file (rom_valid=0 at address 0) gives done=1 with no tokens and err=0.

Decomposition:
- Shared package day01_pkg holds:
  - ASCII constants CH_L=0x4C, CH_R=0x52, CH_NL=0x0A, CH_CR=0x0D, CH_0=0x30, CH_9=0x39.
  - DIR_LEFT=0 and DIR_RIGHT=1.
  - The FSM state encoding.
- One natural sub-module: day01_dec_accum. It is a combinational multiply-by-10-plus-digit with saturation and an overflow flag. The parent keeps all state.

Test Plan:
- ROM "L68\nR48\n", tok_ready=1 -> tokens (0,68) then (1,48); done=1; err=0; no third token.
- Same file, tok_ready held 0 for 10 cycles then 1 -> tok_valid stays 1, (0,68) stable throughout; rom_addr does not advance during the stall; both tokens delivered in order.
- ROM "R5\r\n\nL123" (no trailing newline) -> tokens (1,5) and (0,123); done=1; err=0.
- ROM "X7\nL9\n" -> err=1; only token (0,9); done=1.
- INPUT_DATA_WIDTH=8, ROM "R300\nL2\n" -> token (1,255) with err=1, then (0,2).
- Assert rst mid-way through the second token of the first scenario's file -> all outputs return to reset values; after release, tokens (0,68) and (1,48) are re-emitted from address 0.
